// File: rtl/alarm_pkg.sv
// Constants and types shared between the zone sensor transmitter and the alarm receiver:
// zone encodings, status codes, FSM states and default timing values.
package alarm_pkg;

  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_ALERT_LEN   = 31;
  localparam int DEF_TIMEOUT     = 64;
  localparam int DEF_GAP_CYCLES  = 4;

  localparam int NUM_ZONES = 3;
  localparam int ALERT_W   = 6;

  typedef logic [1:0] zone_t;

  localparam zone_t ZONE_NONE = 2'd0;
  localparam zone_t ZONE_1    = 2'd1;
  localparam zone_t ZONE_2    = 2'd2;
  localparam zone_t ZONE_3    = 2'd3;

  typedef enum logic [1:0] {
    DONE_OK         = 2'd0,
    DONE_TIMEOUT    = 2'd1,
    DONE_WRONG_ZONE = 2'd2,
    DONE_BAD_WIDTH  = 2'd3
  } done_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_MEASURE,
    ST_GAP
  } state_t;

  // Zone z maps to line z-1; zone 0 selects no line at all.
  function automatic logic [NUM_ZONES-1:0] zone_onehot(input zone_t zone);
    case (zone)
      ZONE_1:  return 3'b001;
      ZONE_2:  return 3'b010;
      ZONE_3:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alert_pulse_meter.sv
// Registers the returned buzzer lines, flags rise/fall edges per line and measures
// the width of the selected line's pulse with a saturating counter.
module alert_pulse_meter
  import alarm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_ZONES-1:0] alert_in,
  input  logic [NUM_ZONES-1:0] mask,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 run,
  output logic [NUM_ZONES-1:0] rise,
  output logic [NUM_ZONES-1:0] fall,
  output logic [NUM_ZONES-1:0] level,
  output logic [ALERT_W-1:0]   width,
  output logic                 width_max
);

  localparam logic [ALERT_W-1:0] WIDTH_MAX = '1;

  logic [NUM_ZONES-1:0] alert_p1;
  logic [NUM_ZONES-1:0] prev_p2;
  logic [ALERT_W-1:0]   width_q;

  // Stage 1: input register, sampled even while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alert_p1 <= '0;
    else        alert_p1 <= alert_in;
  end

  // Stage 2: history advances only on enabled cycles so edges are judged there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   prev_p2 <= '0;
    else if (ena) prev_p2 <= alert_p1;
  end

  assign rise  = alert_p1 & ~prev_p2;
  assign fall  = ~alert_p1 & prev_p2;
  assign level = alert_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q <= '0;
    end else if (ena) begin
      if (clr)
        width_q <= '0;
      else if (start)
        width_q <= {{(ALERT_W-1){1'b0}}, 1'b1};
      else if (run && |(alert_p1 & mask) && width_q != WIDTH_MAX)
        width_q <= width_q + 1'b1;
    end
  end

  assign width     = width_q;
  assign width_max = (width_q == WIDTH_MAX);

endmodule

// File: rtl/zone_sensor_tx.sv
// Self-test stimulus engine for the alarm path: drives one zone's sensor line,
// then measures the receiver's alert pulse and reports a status per request.
module zone_sensor_tx
  import alarm_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ALERT_LEN   = DEF_ALERT_LEN,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 req_valid,
  input  logic [1:0]           req_zone,
  output logic                 req_ready,
  output logic [NUM_ZONES-1:0] sensor_out,
  input  logic [NUM_ZONES-1:0] alert_in,
  output logic                 done_valid,
  output logic [1:0]           done_code,
  output logic [ALERT_W-1:0]   alert_width
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ALERT_W-1:0] ALERT_LEN_W = ALERT_W'(ALERT_LEN);

  state_t               state, state_nxt;
  zone_t                zone, zone_nxt;
  logic [NUM_ZONES-1:0] sensor_nxt;
  logic                 done_valid_nxt;
  logic [1:0]           done_code_nxt;
  logic [ALERT_W-1:0]   alert_width_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_nxt;

  logic                 fin, state_chg;
  done_code_t           fin_code;
  logic                 meter_clr, meter_start, meter_run;
  logic [NUM_ZONES-1:0] mask, rise, fall, level;
  logic [ALERT_W-1:0]   width;
  logic                 width_max;
  logic                 match_rise, other_rise, match_fall, match_lvl;

  assign mask       = zone_onehot(zone);
  assign match_rise = |(rise & mask);
  assign other_rise = |(rise & ~mask);
  assign match_fall = |(fall & mask);
  assign match_lvl  = |(level & mask);
  assign req_ready  = (state == ST_IDLE);

  alert_pulse_meter u_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .alert_in  (alert_in),
    .mask      (mask),
    .clr       (meter_clr),
    .start     (meter_start),
    .run       (meter_run),
    .rise      (rise),
    .fall      (fall),
    .level     (level),
    .width     (width),
    .width_max (width_max)
  );

  always_comb begin
    state_nxt       = state;
    zone_nxt        = zone;
    sensor_nxt      = sensor_out;
    done_valid_nxt  = 1'b0;
    done_code_nxt   = done_code;
    alert_width_nxt = alert_width;
    hold_nxt        = hold_cnt;
    wait_nxt        = wait_cnt;
    gap_nxt         = gap_cnt;
    fin             = 1'b0;
    fin_code        = DONE_OK;
    meter_run       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          zone_nxt = req_zone;
          if (req_zone == ZONE_NONE) begin
            fin      = 1'b1;
            fin_code = DONE_WRONG_ZONE;
          end else begin
            state_nxt  = ST_DRIVE;
            sensor_nxt = zone_onehot(req_zone);
          end
        end
      end
      ST_DRIVE: begin
        if (match_rise) begin
          state_nxt  = ST_MEASURE;
          sensor_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt  = ST_WAIT;
          sensor_nxt = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        // A foreign zone answering outranks our own zone in the same cycle
        if (other_rise) begin
          fin      = 1'b1;
          fin_code = DONE_WRONG_ZONE;
        end else if (match_rise) begin
          state_nxt = ST_MEASURE;
        end else if (wait_cnt == WAIT_LAST) begin
          fin      = 1'b1;
          fin_code = DONE_TIMEOUT;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (other_rise) begin
          fin      = 1'b1;
          fin_code = DONE_WRONG_ZONE;
        end else if (match_fall) begin
          fin      = 1'b1;
          fin_code = (width == ALERT_LEN_W) ? DONE_OK : DONE_BAD_WIDTH;
        end else if (width_max && match_lvl) begin
          fin      = 1'b1;
          fin_code = DONE_BAD_WIDTH;
        end else begin
          meter_run = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
        else                     gap_nxt   = gap_cnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (fin) begin
      state_nxt       = ST_GAP;
      sensor_nxt      = '0;
      done_valid_nxt  = 1'b1;
      done_code_nxt   = fin_code;
      alert_width_nxt = width;
    end

    // Every state starts with fresh counters; the width meter is preloaded on MEASURE entry
    state_chg = (state_nxt != state);
    if (state_chg) begin
      hold_nxt = '0;
      wait_nxt = '0;
      gap_nxt  = '0;
    end
    meter_start = state_chg && (state_nxt == ST_MEASURE);
    meter_clr   = state_chg && !meter_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      zone        <= ZONE_NONE;
      sensor_out  <= '0;
      done_valid  <= 1'b0;
      done_code   <= DONE_OK;
      alert_width <= '0;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else if (ena) begin
      state       <= state_nxt;
      zone        <= zone_nxt;
      sensor_out  <= sensor_nxt;
      done_valid  <= done_valid_nxt;
      done_code   <= done_code_nxt;
      alert_width <= alert_width_nxt;
      hold_cnt    <= hold_nxt;
      wait_cnt    <= wait_nxt;
      gap_cnt     <= gap_nxt;
    end
  end

endmodule
